// File: rtl/scan_pkg.sv
// Shared types and constants for the multi-channel sonar scan controller.
package scan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_CMD,
        ST_WAIT_ARG,
        ST_FETCH_ARG,
        ST_WAIT_SERVO,
        ST_START_MEAS,
        ST_MEASURE,
        ST_NEXT_CH,
        ST_WAIT_TX,
        ST_SEND
    } state_t;

    // High nibble of zero selects a control opcode; anything else is a range command.
    localparam logic [3:0] MANUAL    = 4'h0;
    localparam logic [1:0] SET_ANGLE = 2'b00;
    localparam logic [1:0] SET_MODE  = 2'b01;
    localparam logic [1:0] MEASURE   = 2'b10;
    localparam logic [1:0] SET_MASK  = 2'b11;

    localparam logic [7:0] RST_START_ANGLE = 8'h00;
    localparam logic [7:0] RST_END_ANGLE   = 8'hFE;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/sonar_timeout_ctr.sv
// Per-measurement watchdog: expired is high on the TIMEOUT_CYC-th enabled cycle after clear.
module sonar_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired_q) begin
            cnt_d = cnt_q + CW'(1);
        end
        expired_d = (cnt_d == CW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/scan_control_unit.sv
// Host command decoder, round-robin sonar sequencer and packet framer for N_CH sonars.
module scan_control_unit
    import scan_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned TIMEOUT_CYC = 1200000,
    parameter logic [7:0]  TO_DIST     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd,
    input  logic              rx_rdy,
    output logic              cmd_oen,
    input  logic              tx_rdy,
    output logic              data_wen,
    output logic [7:0]        data,
    input  logic [7:0]        servo_angle,
    input  logic              servo_cycle_done,
    output logic [7:0]        start_angle,
    output logic [7:0]        end_angle,
    output logic [N_CH-1:0]   sonar_measure,
    input  logic [N_CH-1:0]   sonar_ready,
    input  logic [8*N_CH-1:0] sonar_distance,
    output logic [7:0]        err_cnt
);

    localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic              arg_mask_q, arg_mask_d;
    logic              tx_hdr_q, tx_hdr_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   pkt_mask_q, pkt_mask_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [7:0]        angle_q, angle_d;
    logic [7:0]        start_q, start_d;
    logic [7:0]        end_q, end_d;
    logic [7:0]        err_q, err_d;
    logic [7:0]        dist_q [N_CH];
    logic [7:0]        dist_d [N_CH];
    logic              cmd_oen_q, cmd_oen_d;
    logic              data_wen_q, data_wen_d;
    logic [7:0]        data_q, data_d;
    logic [N_CH-1:0]   meas_q, meas_d;
    logic [7:0]        dist_in [N_CH];
    logic              tmr_clear_c;
    logic              tmr_expired;

    for (genvar g = 0; g < N_CH; g++) begin : g_dist
        assign dist_in[g] = sonar_distance[8*g +: 8];
    end

    // Lowest enabled channel at or above lo; MSB flags that one was found.
    function automatic logic [CHW:0] pick_ch(input logic [N_CH-1:0] mask, input int lo);
        logic [CHW:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    sonar_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear_c),
        .enable  (state_q == ST_MEASURE),
        .expired (tmr_expired)
    );

    always_comb begin
        logic [CHW:0] pick;
        pick       = '0;
        state_d    = state_q;
        mode_d     = mode_q;
        arg_mask_d = arg_mask_q;
        tx_hdr_d   = tx_hdr_q;
        mask_d     = mask_q;
        pkt_mask_d = pkt_mask_q;
        ch_d       = ch_q;
        angle_d    = angle_q;
        start_d    = start_q;
        end_d      = end_q;
        err_d      = err_q;
        dist_d     = dist_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_rdy)                  state_d = ST_FETCH_CMD;
                else if (mode_q == MODE_AUTO) state_d = ST_WAIT_SERVO;
            end
            ST_FETCH_CMD: begin
                state_d = ST_IDLE;
                if (cmd[7:4] != MANUAL) begin
                    if (cmd[7:4] < cmd[3:0]) begin
                        start_d = {cmd[7:4], 4'h0};
                        end_d   = {cmd[3:0], 4'h0};
                    end else begin
                        start_d = {cmd[3:0], 4'h0};
                        end_d   = {cmd[7:4], 4'h0};
                    end
                end else begin
                    case (cmd[3:2])
                        SET_ANGLE: begin
                            arg_mask_d = 1'b0;
                            state_d    = ST_WAIT_ARG;
                        end
                        SET_MODE: mode_d  = cmd[0] ? MODE_MANUAL : MODE_AUTO;
                        MEASURE:  state_d = ST_START_MEAS;
                        default: begin
                            arg_mask_d = 1'b1;
                            state_d    = ST_WAIT_ARG;
                        end
                    endcase
                end
            end
            ST_WAIT_ARG: begin
                if (rx_rdy) state_d = ST_FETCH_ARG;
            end
            ST_FETCH_ARG: begin
                if (arg_mask_q) begin
                    mask_d = cmd[N_CH-1:0];
                end else begin
                    start_d = cmd;
                    end_d   = cmd;
                end
                state_d = ST_IDLE;
            end
            ST_WAIT_SERVO: begin
                if (servo_cycle_done) state_d = ST_START_MEAS;
                else if (rx_rdy)      state_d = ST_IDLE;
            end
            ST_START_MEAS: begin
                angle_d    = servo_angle;
                pkt_mask_d = mask_q;
                tx_hdr_d   = 1'b1;
                pick       = pick_ch(mask_q, 0);
                if (pick[CHW]) begin
                    ch_d    = pick[CHW-1:0];
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_MEASURE: begin
                // A result arriving on the timeout cycle still counts as a real measurement.
                if (sonar_ready[ch_q]) begin
                    dist_d[ch_q] = dist_in[ch_q];
                    state_d      = ST_NEXT_CH;
                end else if (tmr_expired) begin
                    dist_d[ch_q] = TO_DIST;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    state_d      = ST_NEXT_CH;
                end
            end
            ST_NEXT_CH: begin
                pick = pick_ch(pkt_mask_q, int'(ch_q) + 1);
                if (pick[CHW]) begin
                    ch_d    = pick[CHW-1:0];
                    state_d = ST_MEASURE;
                end else begin
                    tx_hdr_d = 1'b1;
                    state_d  = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (tx_rdy) begin
                    data_d  = tx_hdr_q ? angle_q : dist_q[ch_q];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                pick     = tx_hdr_q ? pick_ch(pkt_mask_q, 0) : pick_ch(pkt_mask_q, int'(ch_q) + 1);
                tx_hdr_d = 1'b0;
                if (pick[CHW]) begin
                    ch_d    = pick[CHW-1:0];
                    state_d = ST_WAIT_TX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tmr_clear_c = (state_d == ST_MEASURE) && (state_q != ST_MEASURE);
        meas_d      = '0;
        if (tmr_clear_c) meas_d[ch_d] = 1'b1;
        cmd_oen_d  = !((state_d == ST_FETCH_CMD) || (state_d == ST_FETCH_ARG));
        data_wen_d = (state_d != ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_AUTO;
            arg_mask_q <= 1'b0;
            tx_hdr_q   <= 1'b0;
            mask_q     <= '1;
            pkt_mask_q <= '1;
            ch_q       <= '0;
            angle_q    <= '0;
            start_q    <= RST_START_ANGLE;
            end_q      <= RST_END_ANGLE;
            err_q      <= '0;
            dist_q     <= '{default: '0};
            cmd_oen_q  <= 1'b1;
            data_wen_q <= 1'b1;
            data_q     <= '0;
            meas_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            arg_mask_q <= arg_mask_d;
            tx_hdr_q   <= tx_hdr_d;
            mask_q     <= mask_d;
            pkt_mask_q <= pkt_mask_d;
            ch_q       <= ch_d;
            angle_q    <= angle_d;
            start_q    <= start_d;
            end_q      <= end_d;
            err_q      <= err_d;
            dist_q     <= dist_d;
            cmd_oen_q  <= cmd_oen_d;
            data_wen_q <= data_wen_d;
            data_q     <= data_d;
            meas_q     <= meas_d;
        end
    end

    assign cmd_oen       = cmd_oen_q;
    assign data_wen      = data_wen_q;
    assign data          = data_q;
    assign start_angle   = start_q;
    assign end_angle     = end_q;
    assign sonar_measure = meas_q;
    assign err_cnt       = err_q;

endmodule
